// File: rtl/multi_clock_gen_pkg.sv
// Shared types and constants for the multi_clock_gen divided-clock generator.
package multi_clock_gen_pkg;

  localparam int NUM_CH = 6;
  localparam int CH_W   = 3;
  localparam int DIV_W  = 16;

  typedef logic [DIV_W-1:0] hp_t;

  localparam hp_t               HP_RST_DEF = hp_t'(1);
  localparam logic [NUM_CH-1:0] EN_RST_DEF = 6'b111111;

  typedef struct packed {
    hp_t  hp;
    logic en;
  } ch_cfg_t;

  // A programmed half-period of 0 behaves exactly like 1.
  function automatic hp_t hp_eff(input hp_t hp);
    return (hp == '0) ? hp_t'(1) : hp;
  endfunction

endpackage

// File: rtl/mcg_channel.sv
// One divided-clock channel: half-period counter, output toggle and a shadow
// config that commits only on a 1->0 output transition (or at once when stopped).
module mcg_channel
  import multi_clock_gen_pkg::*;
#(
  parameter hp_t  HP_RST = hp_t'(1),
  parameter logic EN_RST = 1'b1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    load,
  input  ch_cfg_t cfg,
  output logic    clk_out,
  output logic    busy
`ifdef MULTI_CLOCK_GEN_EDGE_CNT_EN
  , output logic  rise
`endif
);

  hp_t  cnt_q, cnt_d;
  hp_t  hp_q, hp_d;
  hp_t  hp_n_q, hp_n_d;
  logic out_q, out_d;
  logic en_q, en_d;
  logic en_n_q, en_n_d;
  logic pend_q, pend_d;
  logic term, fall, commit;

  always_comb begin
    term   = (cnt_q == (hp_eff(hp_q) - hp_t'(1)));
    fall   = en_q & out_q & term;
    commit = pend_q & (fall | ~en_q);

    cnt_d  = cnt_q;
    out_d  = out_q;
    hp_d   = hp_q;
    en_d   = en_q;
    hp_n_d = hp_n_q;
    en_n_d = en_n_q;
    pend_d = pend_q;

    if (en_q) begin
      if (term) begin
        cnt_d = '0;
        out_d = ~out_q;
      end else begin
        cnt_d = cnt_q + hp_t'(1);
      end
    end else begin
      cnt_d = '0;
      out_d = 1'b0;
    end

    // A request arriving on a boundary cycle waits for the next boundary,
    // because load is only honoured while nothing is pending.
    if (commit) begin
      hp_d   = hp_n_q;
      en_d   = en_n_q;
      pend_d = 1'b0;
    end else if (load) begin
      hp_n_d = cfg.hp;
      en_n_d = cfg.en;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      out_q  <= 1'b0;
      hp_q   <= HP_RST;
      en_q   <= EN_RST;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      hp_q   <= hp_d;
      en_q   <= en_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    hp_n_q <= hp_n_d;
    en_n_q <= en_n_d;
  end

  assign clk_out = out_q;
  assign busy    = pend_q;

`ifdef MULTI_CLOCK_GEN_EDGE_CNT_EN
  assign rise = ~out_q & out_d;
`endif

endmodule

// File: rtl/multi_clock_gen.sv
// Programmable NUM_CH-channel divided-clock generator with valid/ready config.
// Define MULTI_CLOCK_GEN_EDGE_CNT_EN to add per-channel rising-edge counters (edge_cnt).
module multi_clock_gen
  import multi_clock_gen_pkg::*;
#(
  parameter hp_t               HP_RST = HP_RST_DEF,
  parameter logic [NUM_CH-1:0] EN_RST = EN_RST_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [DIV_W-1:0]     cfg_half_period,
  input  logic                 cfg_enable,
  output logic [NUM_CH-1:0]    clk_out,
  output logic [NUM_CH-1:0]    busy
`ifdef MULTI_CLOCK_GEN_EDGE_CNT_EN
  , output logic [NUM_CH*32-1:0] edge_cnt
`endif
);

  ch_cfg_t           cfg_w;
  logic [NUM_CH-1:0] load;

  assign cfg_w = '{hp: cfg_half_period, en: cfg_enable};

  // Out-of-range channel numbers are always ready so the request drains silently.
  always_comb begin
    cfg_ready = 1'b1;
    if (cfg_ch < CH_W'(NUM_CH)) begin
      cfg_ready = ~busy[cfg_ch];
    end
  end

`ifdef MULTI_CLOCK_GEN_EDGE_CNT_EN
  logic [NUM_CH-1:0] rise;
  logic [31:0]       edge_cnt_q [NUM_CH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rst_n) begin
        edge_cnt_q[i] <= '0;
      end else if (rise[i]) begin
        edge_cnt_q[i] <= edge_cnt_q[i] + 32'd1;
      end
    end
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));

    mcg_channel #(
      .HP_RST (HP_RST),
      .EN_RST (EN_RST[i])
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load[i]),
      .cfg     (cfg_w),
      .clk_out (clk_out[i]),
      .busy    (busy[i])
`ifdef MULTI_CLOCK_GEN_EDGE_CNT_EN
      , .rise  (rise[i])
`endif
    );

`ifdef MULTI_CLOCK_GEN_EDGE_CNT_EN
    assign edge_cnt[32*i +: 32] = edge_cnt_q[i];
`endif
  end

endmodule

// File: tb/tb_multi_clock_gen.sv
// Directed, table-driven bench for multi_clock_gen (expected values hand-derived).
module tb_multi_clock_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_ch;
  logic [15:0] cfg_half_period;
  logic        cfg_enable;
  logic [5:0]  clk_out;
  logic [5:0]  busy;
`ifdef MULTI_CLOCK_GEN_EDGE_CNT_EN
  logic [191:0] edge_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_clock_gen dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_ch          (cfg_ch),
    .cfg_half_period (cfg_half_period),
    .cfg_enable      (cfg_enable),
    .clk_out         (clk_out),
    .busy            (busy)
`ifdef MULTI_CLOCK_GEN_EDGE_CNT_EN
    , .edge_cnt      (edge_cnt)
`endif
  );

  typedef struct packed {
    logic        v;
    logic [2:0]  ch;
    logic [15:0] hp;
    logic        en;
    logic        rdy;
    logic [5:0]  out;
    logic [5:0]  bsy;
  } vec_t;

  vec_t tbl [32];

  function automatic vec_t mk(input logic v, input logic [2:0] ch, input logic [15:0] hp,
                              input logic en, input logic rdy, input logic [5:0] out,
                              input logic [5:0] bsy);
    vec_t r;
    r.v = v; r.ch = ch; r.hp = hp; r.en = en; r.rdy = rdy; r.out = out; r.bsy = bsy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; cfg_ready is sampled once settled.
  task automatic drive(input logic v, input logic [2:0] ch, input logic [15:0] hp, input logic en);
    cfg_valid       = v;
    cfg_ch          = ch;
    cfg_half_period = hp;
    cfg_enable      = en;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 16'd0, 1'b0);
    tick();
    tick();
    chk("reset_clk_out", 32'(clk_out), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_ready", 32'(cfg_ready), 32'h1);
    rst_n = 1'b1;
  endtask

  logic exp4 [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    // Rows: inputs held across edge k, ready before edge k, clk_out/busy after edge k.
    tbl[0]  = mk(0, 0, 0, 0, 1, 6'h3F, 6'h00);
    tbl[1]  = mk(1, 2, 3, 1, 1, 6'h00, 6'h04);
    tbl[2]  = mk(0, 2, 0, 0, 0, 6'h3F, 6'h04);
    tbl[3]  = mk(0, 2, 0, 0, 0, 6'h00, 6'h00);
    tbl[4]  = mk(0, 2, 0, 0, 1, 6'h3B, 6'h00);
    tbl[5]  = mk(0, 2, 0, 0, 1, 6'h00, 6'h00);
    tbl[6]  = mk(0, 2, 0, 0, 1, 6'h3F, 6'h00);
    tbl[7]  = mk(0, 2, 0, 0, 1, 6'h04, 6'h00);
    tbl[8]  = mk(0, 2, 0, 0, 1, 6'h3F, 6'h00);
    tbl[9]  = mk(0, 2, 0, 0, 1, 6'h00, 6'h00);
    tbl[10] = mk(0, 2, 0, 0, 1, 6'h3B, 6'h00);
    tbl[11] = mk(1, 0, 4, 1, 1, 6'h00, 6'h01);
    tbl[12] = mk(0, 0, 0, 0, 0, 6'h3F, 6'h01);
    tbl[13] = mk(0, 0, 0, 0, 0, 6'h04, 6'h00);
    tbl[14] = mk(0, 0, 0, 0, 1, 6'h3E, 6'h00);
    tbl[15] = mk(0, 0, 0, 0, 1, 6'h00, 6'h00);
    tbl[16] = mk(0, 0, 0, 0, 1, 6'h3A, 6'h00);
    tbl[17] = mk(0, 0, 0, 0, 1, 6'h01, 6'h00);
    tbl[18] = mk(1, 0, 5, 0, 1, 6'h3F, 6'h01);
    tbl[19] = mk(0, 0, 0, 0, 0, 6'h05, 6'h01);
    tbl[20] = mk(0, 0, 0, 0, 0, 6'h3F, 6'h01);
    tbl[21] = mk(0, 0, 0, 0, 0, 6'h00, 6'h00);
    tbl[22] = mk(0, 0, 0, 0, 1, 6'h3A, 6'h00);
    tbl[23] = mk(0, 0, 0, 0, 1, 6'h00, 6'h00);
    tbl[24] = mk(1, 0, 5, 1, 1, 6'h3E, 6'h01);
    tbl[25] = mk(0, 0, 0, 0, 0, 6'h04, 6'h00);
    tbl[26] = mk(0, 0, 0, 0, 1, 6'h3E, 6'h00);
    tbl[27] = mk(0, 0, 0, 0, 1, 6'h00, 6'h00);
    tbl[28] = mk(0, 0, 0, 0, 1, 6'h3A, 6'h00);
    tbl[29] = mk(0, 0, 0, 0, 1, 6'h00, 6'h00);
    tbl[30] = mk(0, 0, 0, 0, 1, 6'h3F, 6'h00);
    tbl[31] = mk(0, 0, 0, 0, 1, 6'h05, 6'h00);

    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(tbl[i].v, tbl[i].ch, tbl[i].hp, tbl[i].en);
      chk($sformatf("row%0d_ready", i + 1), 32'(cfg_ready), 32'(tbl[i].rdy));
      tick();
      chk($sformatf("row%0d_clk_out", i + 1), 32'(clk_out), 32'(tbl[i].out));
      chk($sformatf("row%0d_busy", i + 1), 32'(busy), 32'(tbl[i].bsy));
    end

    // Back-to-back writes to ch4: second held until the first commits.
    do_reset();
    drive(1, 3'd4, 16'd2, 1);
    chk("b2b_ready1", 32'(cfg_ready), 32'h1);
    tick();
    chk("b2b_busy_t1", 32'(busy[4]), 32'h1);
    chk("b2b_out_t1", 32'(clk_out[4]), 32'h1);
    drive(1, 3'd4, 16'd3, 1);
    chk("b2b_ready_held", 32'(cfg_ready), 32'h0);
    tick();
    chk("b2b_busy_t2", 32'(busy[4]), 32'h0);
    chk("b2b_out_t2", 32'(clk_out[4]), 32'h0);
    drive(1, 3'd4, 16'd3, 1);
    chk("b2b_ready2", 32'(cfg_ready), 32'h1);
    tick();
    chk("b2b_busy_t3", 32'(busy[4]), 32'h1);
    chk("b2b_out_t3", 32'(clk_out[4]), 32'h0);
    drive(0, 3'd4, 16'd0, 0);
    for (int k = 0; k < 9; k++) begin
      tick();
      chk($sformatf("b2b_out_t%0d", k + 4), 32'(clk_out[4]), 32'(exp4[k]));
      if (k == 2) chk("b2b_busy_t6", 32'(busy[4]), 32'h0);
    end

    // Out-of-range channel is dropped; hp=0 behaves as hp=1.
    do_reset();
    drive(1, 3'd7, 16'd5, 0);
    chk("ch7_ready", 32'(cfg_ready), 32'h1);
    tick();
    chk("ch7_busy", 32'(busy), 32'h0);
    chk("ch7_out", 32'(clk_out), 32'h3F);
    drive(1, 3'd1, 16'd0, 1);
    tick();
    chk("hp0_busy_t2", 32'(busy), 32'h02);
    chk("hp0_out_t2", 32'(clk_out), 32'h00);
    drive(0, 3'd1, 16'd0, 0);
    tick();
    chk("hp0_out_t3", 32'(clk_out), 32'h3F);
    tick();
    chk("hp0_busy_t4", 32'(busy), 32'h00);
    for (int k = 5; k <= 8; k++) begin
      tick();
      chk($sformatf("hp0_out_t%0d", k), 32'(clk_out), (k % 2 == 1) ? 32'h3F : 32'h00);
    end

    // Reset while a ch5 update is pending.
    do_reset();
    drive(1, 3'd5, 16'd4, 1);
    tick();
    chk("rstp_busy_t1", 32'(busy), 32'h20);
    chk("rstp_out_t1", 32'(clk_out), 32'h3F);
    drive(0, 3'd5, 16'd0, 0);
    rst_n = 1'b0;
    tick();
    chk("rstp_out_rst", 32'(clk_out), 32'h00);
    chk("rstp_busy_rst", 32'(busy), 32'h00);
    chk("rstp_ready_rst", 32'(cfg_ready), 32'h1);
    rst_n = 1'b1;
    tick();
    chk("rstp_out_r1", 32'(clk_out), 32'h3F);
    tick();
    chk("rstp_out_r2", 32'(clk_out), 32'h00);
    chk("rstp_busy_r2", 32'(busy), 32'h00);

`ifdef MULTI_CLOCK_GEN_EDGE_CNT_EN
    do_reset();
    for (int k = 0; k < 20; k++) tick();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("edge_cnt%0d", i), edge_cnt[32*i +: 32], 32'd10);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
